// File: rtl/and_in_pkg.sv
// Shared constants for the four-channel input debounce stage.
package and_in_pkg;

  localparam int NUM_CH              = 4;
  localparam int STABLE_CYCLES_DEF   = 16;
  localparam int SYNC_STAGES_DEF     = 2;

  typedef enum logic {
    CH_IDLE    = 1'b0,
    CH_PENDING = 1'b1
  } ch_state_t;

  // Counter must hold STABLE_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles > 1) ? $clog2(stable_cycles) : 1;
  endfunction

endpackage

// File: rtl/and_in_debounce_if.sv
// Raw lines in, debounced levels out; chg_pulse exists only with AND_IN_DEBOUNCE_PULSE_EN.
interface and_in_debounce_if;

  logic [3:0] raw_in;
  logic       in1;
  logic       in2;
  logic       in3;
  logic       in4;
  logic       all_stable;
`ifdef AND_IN_DEBOUNCE_PULSE_EN
  logic [3:0] chg_pulse;
`endif

  modport master (
    output raw_in,
    input  in1, in2, in3, in4, all_stable
`ifdef AND_IN_DEBOUNCE_PULSE_EN
    , input chg_pulse
`endif
  );

  modport slave (
    input  raw_in,
    output in1, in2, in3, in4, all_stable
`ifdef AND_IN_DEBOUNCE_PULSE_EN
    , output chg_pulse
`endif
  );

endinterface

// File: rtl/and_in_debounce_ch.sv
// One channel: synchronizer, stability counter and debounced register.
// Optional change pulse under AND_IN_DEBOUNCE_PULSE_EN.
//
// state   | meaning
// IDLE    | synchronized level equals debounced level, counter at 0
// PENDING | levels differ, counting consecutive mismatched cycles
module and_in_debounce_ch
  import and_in_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic d,
  output logic match
`ifdef AND_IN_DEBOUNCE_PULSE_EN
  , output logic chg_pulse
`endif
);

  localparam int              CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic                   d_n;
  ch_state_t              state_q, state_n;

  assign s     = sync[SYNC_STAGES-1];
  assign match = (s == d);

  always_ff @(posedge clk) begin
    if (rst) begin
      sync    <= '0;
      cnt_q   <= '0;
      d       <= 1'b0;
      state_q <= CH_IDLE;
    end else begin
      sync    <= {sync[SYNC_STAGES-2:0], raw};
      cnt_q   <= cnt_n;
      d       <= d_n;
      state_q <= state_n;
    end
  end

  always_comb begin
    state_n = CH_IDLE;
    cnt_n   = '0;
    d_n     = d;
    case (state_q)
      CH_IDLE: begin
        if (!match) begin
          // With a threshold of one cycle the first mismatch commits directly.
          if (cnt_q == CNT_MAX) begin
            d_n = s;
          end else begin
            cnt_n   = cnt_q + 1'b1;
            state_n = CH_PENDING;
          end
        end
      end
      CH_PENDING: begin
        if (!match) begin
          if (cnt_q == CNT_MAX) begin
            d_n = s;
          end else begin
            cnt_n   = cnt_q + 1'b1;
            state_n = CH_PENDING;
          end
        end
      end
      default: begin
        state_n = CH_IDLE;
      end
    endcase
  end

`ifdef AND_IN_DEBOUNCE_PULSE_EN
  always_ff @(posedge clk) begin
    if (rst) chg_pulse <= 1'b0;
    else     chg_pulse <= (d_n != d);
  end
`endif

endmodule

// File: rtl/and_in_debounce.sv
// Four-channel synchronize-and-debounce stage feeding and_gate_func.
// Define AND_IN_DEBOUNCE_PULSE_EN to add the registered chg_pulse output.
module and_in_debounce
  import and_in_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int SYNC_STAGES   = SYNC_STAGES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  and_in_debounce_if.slave  bus
);

  logic [NUM_CH-1:0] d_vec;
  logic [NUM_CH-1:0] match_vec;
`ifdef AND_IN_DEBOUNCE_PULSE_EN
  logic [NUM_CH-1:0] pulse_vec;
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    and_in_debounce_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .raw       (bus.raw_in[i]),
      .d         (d_vec[i]),
      .match     (match_vec[i])
`ifdef AND_IN_DEBOUNCE_PULSE_EN
      , .chg_pulse (pulse_vec[i])
`endif
    );
  end

  assign bus.in1        = d_vec[0];
  assign bus.in2        = d_vec[1];
  assign bus.in3        = d_vec[2];
  assign bus.in4        = d_vec[3];
  assign bus.all_stable = &match_vec;
`ifdef AND_IN_DEBOUNCE_PULSE_EN
  assign bus.chg_pulse  = pulse_vec;
`endif

endmodule

// File: tb/tb_and_in_debounce.sv
// Directed scoreboard bench for and_in_debounce with STABLE_CYCLES=4, SYNC_STAGES=2.
module tb_and_in_debounce;
  import and_in_pkg::*;

  typedef struct {
    string      tag;
    logic [3:0] d;
    logic       st;
    logic       aout;
    logic [3:0] pulse;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [3:0] prev_d = 4'h0;

  and_in_debounce_if bus ();

  and_in_debounce #(
    .STABLE_CYCLES (4),
    .SYNC_STAGES   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Stand-in for and_gate_func attached downstream.
  logic and_out;
  assign and_out = bus.in1 & bus.in2 & bus.in3 & bus.in4;

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One edge: drive inputs, record expected post-edge outputs, then compare.
  task automatic step(input string tag, input logic r, input logic [3:0] raw,
                      input logic [3:0] ed, input logic es);
    exp_t e;
    logic [3:0] obs_d;
    @(negedge clk);
    rst        = r;
    bus.raw_in = raw;
    e.tag   = tag;
    e.d     = ed;
    e.st    = es;
    e.aout  = &ed;
    e.pulse = r ? 4'h0 : (ed ^ prev_d);
    prev_d  = ed;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    obs_d = {bus.in4, bus.in3, bus.in2, bus.in1};
    chk_vec({e.tag, ".d"}, obs_d, e.d);
    chk_bit({e.tag, ".all_stable"}, bus.all_stable, e.st);
    chk_bit({e.tag, ".and_out"}, and_out, e.aout);
`ifdef AND_IN_DEBOUNCE_PULSE_EN
    chk_vec({e.tag, ".chg_pulse"}, bus.chg_pulse, e.pulse);
`endif
  endtask

  initial begin
    bus.raw_in = 4'h0;

    // Reset with all raw lines high
    for (int i = 0; i < 3; i++) step("rst", 1'b1, 4'hF, 4'h0, 1'b1);

    // Assert all lines: outputs rise together at edge 6
    step("asrt_e1", 1'b0, 4'hF, 4'h0, 1'b1);
    for (int i = 2; i <= 5; i++) step("asrt_pend", 1'b0, 4'hF, 4'h0, 1'b0);
    step("asrt_e6", 1'b0, 4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 2; i++) step("asrt_hold", 1'b0, 4'hF, 4'hF, 1'b1);

    // Partial release: only channel 0 falls
    step("rel_e1", 1'b0, 4'hE, 4'hF, 1'b1);
    for (int i = 2; i <= 5; i++) step("rel_pend", 1'b0, 4'hE, 4'hF, 1'b0);
    step("rel_e6", 1'b0, 4'hE, 4'hE, 1'b1);
    step("rel_hold", 1'b0, 4'hE, 4'hE, 1'b1);

    // Three-cycle glitch on channel 0 is rejected
    step("gl_e1", 1'b0, 4'hF, 4'hE, 1'b1);
    step("gl_e2", 1'b0, 4'hF, 4'hE, 1'b0);
    step("gl_e3", 1'b0, 4'hF, 4'hE, 1'b0);
    step("gl_e4", 1'b0, 4'hE, 4'hE, 1'b0);
    step("gl_e5", 1'b0, 4'hE, 4'hE, 1'b1);
    for (int i = 0; i < 4; i++) step("gl_hold", 1'b0, 4'hE, 4'hE, 1'b1);

    // Reset at edge 4 of a pending rise, then full latency again
    step("rm_e1", 1'b0, 4'hF, 4'hE, 1'b1);
    step("rm_e2", 1'b0, 4'hF, 4'hE, 1'b0);
    step("rm_e3", 1'b0, 4'hF, 4'hE, 1'b0);
    step("rm_rst", 1'b1, 4'hF, 4'h0, 1'b1);
    step("rm_p1", 1'b0, 4'hF, 4'h0, 1'b1);
    for (int i = 2; i <= 5; i++) step("rm_pend", 1'b0, 4'hF, 4'h0, 1'b0);
    step("rm_p6", 1'b0, 4'hF, 4'hF, 1'b1);
    step("rm_hold", 1'b0, 4'hF, 4'hF, 1'b1);

    // Independent channels settling on the same edge fall together
    step("fall_e1", 1'b0, 4'h5, 4'hF, 1'b1);
    for (int i = 2; i <= 5; i++) step("fall_pend", 1'b0, 4'h5, 4'hF, 1'b0);
    step("fall_e6", 1'b0, 4'h5, 4'h5, 1'b1);

    chk_bit("sb_empty", (sb.size() == 0), 1'b1);
    chk_bit("num_ch", (NUM_CH == 4), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
